cbus_rr_arbiter: RTL and testbench

//  Shares the single external cbus between N cache-side masters (ICache, DCache, later the uncached

---
 rtl/cbus_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// cbus request/response types and a burst-granular round-robin arbiter with an optional
// preferred master and a starvation guard, sharing one cbus between NUM_INPUTS masters.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_INPUTS   = 2,
  parameter int unsigned PRIO_EN      = 1,
  parameter int unsigned PRIO_IDX     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned IdxW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IdxW-1:0] PrioSel  = IdxW'(PRIO_IDX);
  localparam logic [IdxW-1:0] LastSel  = IdxW'(NUM_INPUTS - 1);
  localparam logic [3:0]      StarveMx = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_sel;
  logic [IdxW-1:0] r_rr_ptr;
  logic [3:0]      r_starve_cnt [NUM_INPUTS];

  logic [NUM_INPUTS-1:0] w_valid;
  logic                  w_burst_end;
  logic                  w_starve_hit;
  logic                  w_rr_hit;
  logic [IdxW-1:0]       w_starve_idx;
  logic [IdxW-1:0]       w_rr_idx;
  logic [IdxW-1:0]       w_winner;
  logic [IdxW-1:0]       w_sel_next;

  // Position k of the round-robin scan that starts at base.
  function automatic logic [IdxW-1:0] rr_index(input logic [IdxW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    return IdxW'(s % NUM_INPUTS);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      w_valid[i] = ireqs[i].valid;
    end
  end

  assign w_burst_end = (r_state == StBusy) && oresp.ready && oresp.last;
  assign w_sel_next  = (r_sel == LastSel) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_idx = '0;
    w_rr_hit     = 1'b0;
    w_rr_idx     = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (!w_starve_hit && w_valid[rr_index(r_rr_ptr, k)] &&
          (r_starve_cnt[rr_index(r_rr_ptr, k)] == StarveMx)) begin
        w_starve_hit = 1'b1;
        w_starve_idx = rr_index(r_rr_ptr, k);
      end
      if (!w_rr_hit && w_valid[rr_index(r_rr_ptr, k)]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = rr_index(r_rr_ptr, k);
      end
    end
    if (w_starve_hit) begin
      w_winner = w_starve_idx;
    end else if ((PRIO_EN != 0) && w_valid[PrioSel]) begin
      w_winner = PrioSel;
    end else begin
      w_winner = w_rr_idx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        r_starve_cnt[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_valid) begin
            r_sel   <= w_winner;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          // sel stays locked until the final beat, even if the master drops valid.
          if (w_burst_end) begin
            r_state  <= StIdle;
            r_rr_ptr <= w_sel_next;
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
              if (IdxW'(i) == r_sel) begin
                r_starve_cnt[i] <= '0;
              end else if (w_valid[i] && (r_starve_cnt[i] < StarveMx)) begin
                r_starve_cnt[i] <= r_starve_cnt[i] + 4'd1;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    oreq = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      iresps[i] = '0;
    end
    if (r_state == StBusy) begin
      oreq          = ireqs[r_sel];
      iresps[r_sel] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: a cycle table on a PRIO_EN=1 instance plus hand-written
// starvation, pure round-robin and mid-burst reset sequences.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  ireqs     [2];
  cbus_resp_t iresps    [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  cbus_req_t  rr_ireqs  [2];
  cbus_resp_t rr_iresps [2];
  cbus_req_t  rr_oreq;
  cbus_resp_t rr_oresp;

  always #5 clk = ~clk;

  cbus_rr_arbiter #(
    .NUM_INPUTS(2), .PRIO_EN(1), .PRIO_IDX(1), .STARVE_LIMIT(4)
  ) u_dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
  );

  cbus_rr_arbiter #(
    .NUM_INPUTS(2), .PRIO_EN(0), .PRIO_IDX(1), .STARVE_LIMIT(4)
  ) u_dut_rr (
    .clk(clk), .resetn(resetn), .ireqs(rr_ireqs), .iresps(rr_iresps), .oreq(rr_oreq),
    .oresp(rr_oresp)
  );

  typedef struct {
    logic       v0, v1, rdy, last;
    logic [1:0] gnt;   // 0 none, 1 master0, 2 master1
    logic       eov, er0, er1;
  } vec_t;

  vec_t       vq [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         got [$];
  int         both;
  int         g_starve [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int         g_rr [5] = '{0, 1, 0, 1, 0};
  logic [7:0] exp_addr;

  function automatic cbus_req_t mk_req(input logic v, input logic [31:0] addr);
    cbus_req_t r;
    r = '0;
    r.valid = v;
    r.size = 3'd2;
    r.addr = addr;
    r.strobe = 4'hf;
    r.data = addr ^ 32'h1234_0000;
    r.len = 8'd3;
    return r;
  endfunction

  task automatic drive(input logic v0, input logic v1, input logic rdy, input logic last);
    ireqs[0] = mk_req(v0, 32'h0000_00a0);
    ireqs[1] = mk_req(v1, 32'h0000_00b1);
    oresp = '{ready: rdy, last: last, data: 32'h5d};
  endtask

  task automatic drive_rr(input logic v0, input logic v1, input logic rdy, input logic last);
    rr_ireqs[0] = mk_req(v0, 32'h0000_00a0);
    rr_ireqs[1] = mk_req(v1, 32'h0000_00b1);
    rr_oresp = '{ready: rdy, last: last, data: 32'h6e};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v0, input logic v1, input logic rdy, input logic last,
                     input logic [1:0] gnt, input logic eov, input logic er0, input logic er1);
    vec_t v;
    v = '{v0, v1, rdy, last, gnt, eov, er0, er1};
    vq.push_back(v);
  endtask

  initial begin
    // Cycle table: v0 v1 rdy last | grant oreq.valid iresp0.ready iresp1.ready
    add(1, 0, 0, 0, 0, 0, 0, 0);  // master0 alone, 4-beat burst with a wait state
    add(1, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0);  // oresp in IDLE ignored
    add(1, 1, 0, 0, 0, 0, 0, 0);  // tie: preferred master1 first
    add(1, 1, 1, 1, 2, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);  // dead cycle
    add(1, 0, 1, 1, 1, 1, 1, 0);  // master0 at last1+2
    add(0, 1, 0, 0, 0, 0, 0, 0);  // master1 drops valid mid-burst
    add(0, 1, 1, 0, 2, 1, 0, 1);
    add(1, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 1, 0, 2, 0, 0, 1);
    add(1, 0, 1, 1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    resetn = 1'b0;
    drive(1, 1, 1, 1);
    drive_rr(1, 1, 1, 1);
    #3;
    check("reset_oreq", oreq, '0);
    check("reset_iresp0", iresps[0], '0);
    check("reset_iresp1", iresps[1], '0);
    check("reset_rr_oreq", rr_oreq, '0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    drive_rr(0, 0, 0, 0);
    resetn = 1'b1;

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      drive(vq[n].v0, vq[n].v1, vq[n].rdy, vq[n].last);
      #1;
      exp_addr = (vq[n].gnt == 2'd1) ? 8'ha0 : (vq[n].gnt == 2'd2) ? 8'hb1 : 8'h00;
      check($sformatf("vec%0d", n),
            {oreq.valid, oreq.addr[7:0], iresps[0].ready, iresps[1].ready},
            {vq[n].eov, exp_addr, vq[n].er0, vq[n].er1});
    end

    // Starvation guard: master1 keeps winning until master0 has lost 4 times.
    both = 0;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1, 1, 1, 1);
      #1;
      if (iresps[0].ready && iresps[1].ready) both++;
      else if (iresps[1].ready) got.push_back(1);
      else if (iresps[0].ready) got.push_back(0);
    end
    check("starve_grants", got.size(), 10);
    check("starve_onehot", both, 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("starve_g%0d", i), (i < got.size()) ? got[i] : 99, g_starve[i]);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);

    // Pure round-robin instance alternates, leaving rr_ptr at 1.
    both = 0;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive_rr(1, 1, 1, 1);
      #1;
      if (rr_iresps[0].ready && rr_iresps[1].ready) both++;
      else if (rr_iresps[1].ready) got.push_back(1);
      else if (rr_iresps[0].ready) got.push_back(0);
    end
    check("rr_grants", got.size(), 5);
    check("rr_onehot", both, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_g%0d", i), (i < got.size()) ? got[i] : 99, g_rr[i]);
    end
    @(negedge clk);
    drive_rr(0, 0, 0, 0);

    // Reset during beat 2 of a 4-beat burst.
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    check("rst_beat1", iresps[0].ready, 1);
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    check("rst_beat2", iresps[0].ready, 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_oreq", oreq, '0);
    check("rst_mid_iresp0", iresps[0], '0);
    check("rst_mid_iresp1", iresps[1], '0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 1, 0, 0);
    drive_rr(1, 1, 0, 0);
    #1;
    check("post_rst_idle", oreq.valid, 0);
    check("post_rst_rr_idle", rr_oreq.valid, 0);
    @(negedge clk);
    #1;
    check("post_rst_prio", {oreq.valid, oreq.addr[7:0]}, {1'b1, 8'hb1});
    check("post_rst_rr_ptr0", {rr_oreq.valid, rr_oreq.addr[7:0]}, {1'b1, 8'ha0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
